// File: rtl/memoria_datos_bram.sv
// rtl/memoria_datos_bram.sv - single-port data RAM for the MEM stage, registered read, block-RAM template
// Optional macro: MEMORIA_DATOS_WRITE_FIRST_EN selects write-first read-during-write behaviour.
module memoria_datos_bram #(
    parameter int RAM_WIDTH       = 16,
    parameter int RAM_DEPTH       = 1024,
    parameter     RAM_PERFORMANCE = "LOW_LATENCY",
    parameter     INIT_FILE       = ""
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [15:0]          i_addr,
    input  logic [RAM_WIDTH-1:0] i_data,
    input  logic                 wea,
    input  logic                 regcea,
    output logic [RAM_WIDTH-1:0] o_data
);

    localparam int AW = $clog2(RAM_DEPTH);

    logic [RAM_WIDTH-1:0] r_mem [0:RAM_DEPTH-1];
    logic [RAM_WIDTH-1:0] r_ram_data;
    logic [AW-1:0]        w_addr;
    logic                 w_unused;

    // Upper address bits are dropped so accesses wrap modulo RAM_DEPTH.
    assign w_addr   = i_addr[AW-1:0];
    assign w_unused = ^{i_addr, regcea};

    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) begin
            r_mem[i] = '0;
        end
    end

    // Memory contents survive reset; a write coinciding with reset is dropped.
    always @(posedge i_clk) begin
        if (!i_reset && wea) begin
            r_mem[w_addr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ram_data <= '0;
        end else begin
`ifdef MEMORIA_DATOS_WRITE_FIRST_EN
            r_ram_data <= wea ? i_data : r_mem[w_addr];
`else
            r_ram_data <= r_mem[w_addr];
`endif
        end
    end

    generate
        if (RAM_PERFORMANCE == "HIGH_PERFORMANCE") begin : g_high_perf
            logic [RAM_WIDTH-1:0] r_o_reg;

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_o_reg <= '0;
                end else if (regcea) begin
                    r_o_reg <= r_ram_data;
                end
            end

            assign o_data = r_o_reg;
        end else begin : g_low_latency
            // Any unrecognised performance string falls back to this path.
            assign o_data = r_ram_data;
        end
    endgenerate

endmodule

// File: tb/tb_memoria_datos_bram.sv
// tb/tb_memoria_datos_bram.sv - scoreboard bench for memoria_datos_bram in both latency modes
module tb_memoria_datos_bram;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [15:0] i_addr;
    logic [15:0] i_data;
    logic        wea;
    logic        regcea;
    logic [15:0] o_data_ll;
    logic [15:0] o_data_hp;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    typedef struct {
        int          due;
        bit          hp;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memoria_datos_bram #(
        .RAM_WIDTH(16), .RAM_DEPTH(1024), .RAM_PERFORMANCE("LOW_LATENCY"), .INIT_FILE("")
    ) dut_ll (
        .i_clk(clk), .i_reset(i_reset), .i_addr(i_addr), .i_data(i_data),
        .wea(wea), .regcea(regcea), .o_data(o_data_ll)
    );

    memoria_datos_bram #(
        .RAM_WIDTH(16), .RAM_DEPTH(1024), .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .INIT_FILE("")
    ) dut_hp (
        .i_clk(clk), .i_reset(i_reset), .i_addr(i_addr), .i_data(i_data),
        .wea(wea), .regcea(regcea), .o_data(o_data_hp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input int dly, input bit hp, input logic [15:0] v, input string nm);
        exp_t e;
        e.due  = cyc + dly;
        e.hp   = hp;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        int i;
        logic [15:0] act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due <= cyc) begin
                act = sb[i].hp ? o_data_hp : o_data_ll;
                vectors++;
                if (sb[i].due < cyc || act !== sb[i].val) begin
                    miscompares++;
                    $display("FAIL %s (%s) cyc=%0d: got 0x%04h, expected 0x%04h",
                             sb[i].name, sb[i].hp ? "hp" : "ll", cyc, act, sb[i].val);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        i_reset = 1'b1;
        i_addr  = 16'h0000;
        i_data  = 16'h0000;
        wea     = 1'b0;
        regcea  = 1'b1;

        step();
        step();
        vectors++;
        if (o_data_ll !== 16'h0000) begin
            miscompares++;
            $display("FAIL direct_reset_ll: got 0x%04h", o_data_ll);
        end
        vectors++;
        if (o_data_hp !== 16'h0000) begin
            miscompares++;
            $display("FAIL direct_reset_hp: got 0x%04h", o_data_hp);
        end
        expect_v(0, 0, 16'h0000, "reset_ll");
        expect_v(0, 1, 16'h0000, "reset_hp");
        i_reset = 1'b0;
        expect_v(1, 0, 16'h0000, "init_addr0_ll");
        expect_v(2, 1, 16'h0000, "init_addr0_hp");

        step();
        i_addr = 16'h0000; i_data = 16'h000F; wea = 1'b1;
        step();
        wea = 1'b0;
        expect_v(1, 0, 16'h000F, "write_f_ll");
        expect_v(2, 1, 16'h000F, "write_f_hp");
        step();
        i_data = 16'h0001; wea = 1'b1;
        step();
        wea = 1'b0;
        expect_v(1, 0, 16'h0001, "overwrite_ll");
        expect_v(2, 1, 16'h0001, "overwrite_hp");

        step();
        i_addr = 16'h0001; i_data = 16'h0002; wea = 1'b1;
        step();
        wea = 1'b0; i_addr = 16'h0000;
        expect_v(1, 0, 16'h0001, "two_addr0_ll");
        expect_v(2, 1, 16'h0001, "two_addr0_hp");
        step();
        i_addr = 16'h0001;
        expect_v(1, 0, 16'h0002, "two_addr1_ll");
        expect_v(2, 1, 16'h0002, "two_addr1_hp");

        step();
        i_data = 16'h0086; wea = 1'b1;
`ifdef MEMORIA_DATOS_WRITE_FIRST_EN
        expect_v(1, 0, 16'h0086, "rdw_write_edge_ll");
        expect_v(2, 1, 16'h0086, "rdw_write_edge_hp");
`else
        expect_v(1, 0, 16'h0002, "rdw_write_edge_ll");
        expect_v(2, 1, 16'h0002, "rdw_write_edge_hp");
`endif
        step();
        wea = 1'b0;
        expect_v(1, 0, 16'h0086, "rdw_next_ll");
        expect_v(2, 1, 16'h0086, "rdw_next_hp");

        step();
        regcea = 1'b1; i_addr = 16'h0000;
        expect_v(1, 0, 16'h0001, "hp_read0_ll");
        expect_v(1, 1, 16'h0086, "hp_lag_one_edge");
        expect_v(2, 1, 16'h0001, "hp_read0_two_edges");
        step();
        step();
        regcea = 1'b0; i_addr = 16'h0001;
        expect_v(1, 0, 16'h0086, "ll_ignores_regcea");
        expect_v(1, 1, 16'h0001, "hp_hold1");
        expect_v(3, 1, 16'h0001, "hp_hold3");
        step();
        step();
        step();
        i_reset = 1'b1;
        step();
        vectors++;
        if (o_data_hp !== 16'h0000) begin
            miscompares++;
            $display("FAIL direct_hp_reset_over_regcea: got 0x%04h", o_data_hp);
        end
        vectors++;
        if (o_data_ll !== 16'h0000) begin
            miscompares++;
            $display("FAIL direct_ll_reset: got 0x%04h", o_data_ll);
        end
        expect_v(0, 1, 16'h0000, "hp_reset_over_regcea");
        expect_v(0, 0, 16'h0000, "ll_reset");
        i_reset = 1'b0; regcea = 1'b1;

        step();
        i_addr = 16'h0400; i_data = 16'h1234; wea = 1'b1;
        step();
        wea = 1'b0; i_addr = 16'h0000;
        expect_v(1, 0, 16'h1234, "wrap_ll");
        expect_v(2, 1, 16'h1234, "wrap_hp");
        step();
        i_addr = 16'hFC01;
        expect_v(1, 0, 16'h0086, "wrap_hi_bits_ll");

        step();
        i_reset = 1'b1; wea = 1'b1; i_addr = 16'h0000; i_data = 16'hDEAD;
        step();
        i_reset = 1'b0; wea = 1'b0;
        expect_v(0, 0, 16'h0000, "reset_write_out_ll");
        expect_v(1, 0, 16'h1234, "reset_write_suppressed_ll");
        expect_v(2, 1, 16'h1234, "reset_write_suppressed_hp");

        for (int k = 0; k < 20 && sb.size() > 0; k++) step();
        while (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s never checked (due cyc %0d)", sb[0].name, sb[0].due);
            void'(sb.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
